dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Two-port arbiter and access sequencer in front of the single-port word-addressed data memory. Shares the memory between requester 0 (core load/store path) and requester 1 (DMA/debug path) with round-robin fairness. Converts sub-word stores into read-modify-write sequences and rejects out-of-range addresses. Sits between the core/DMA and data_memory-style storage. Memory read data is valid in the cycle after mem_read is asserted.

Parameters:
MEM_WORDS, 1024, number of 32-bit words in the backing memory; word index = address >> 2.
FIXED_PRIO, 0, 1 = requester 0 always wins ties; 0 = round-robin.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
req0_valid  in  1  requester 0 has a request; held with fields stable until req0_ready.
req0_write  in  1  1 = store, 0 = load.
req0_address  in  32  byte address; bits [1:0] ignored.
req0_wdata  in  32  store data.
req0_byte_en  in  4  store byte lanes; bit i = bits [8i+7:8i]; ignored for loads.
req0_ready  out  1  accept pulse for requester 0.
resp0_valid  out  1  one-cycle completion pulse for requester 0.
resp0_rdata  out  32  load data or final stored word; valid with resp0_valid.
resp0_err  out  1  out-of-range address; valid with resp0_valid.
req1_* / resp1_*  same set as requester 0, for requester 1.
mem_read  out  1  memory read strobe.
mem_write  out  1  memory write strobe.
mem_address  out  32  word-aligned byte address; [1:0] = 0.
mem_write_data  out  32  memory write data.
mem_read_data  in  32  memory read data; sampled in the cycle after mem_read.

Behaviour:
- Reset:
  - All outputs 0, FSM to IDLE, round-robin pointer favours requester 0.
  - Reset mid-operation drops the in-flight request: no response, no further memory strobe.
- FSM states: IDLE, RD, RD_CAP, WR, RESP.
- IDLE:
  - Grant when any valid is set.
  - Both valid: round-robin picks the requester not granted last; FIXED_PRIO=1 always picks 0.
  - reqN_ready is combinational, only in IDLE, to the winner only.
  - Capture write, address, wdata, byte_en, and id on that edge.
  - Flip the pointer after each grant.
- Decode of the captured request, with next state:
  - (address >> 2) >= MEM_WORDS → RESP, err=1, rdata=0, no memory strobe.
  - load → RD.
  - store, byte_en = 4'b1111 → WR, merged word = wdata.
  - store, byte_en = 4'b0000 → RESP with no memory access; rdata=0, err=0.
  - store, partial byte_en → RD (read-modify-write).
- RD: mem_read=1 for exactly one cycle → RD_CAP.
- RD_CAP:
  - Register mem_read_data.
  - Load → RESP, rdata = read word.
  - RMW → WR; merged word takes wdata on lanes with byte_en=1 and the read word elsewhere.
- WR: mem_write=1 for one cycle with mem_write_data = merged word → RESP; rdata = merged word.
- RESP: respN_valid=1 for one cycle, to the owning requester only → IDLE.
- Timing from accept edge T:
  - load: resp at T+3.
  - full store: resp at T+2.
  - RMW store: resp at T+4.
  - error or empty store: resp at T+1.
- Throughput: the next grant is possible in the IDLE cycle following RESP.
- Invariants:
  - mem_read and mem_write are never high together.
  - mem_address, mem_write_data are 0 whenever both strobes are low.
  - resp0_valid and resp1_valid are never high together.
- Requester deasserting valid before ready is legal; it is simply not granted.

Test Plan:
- Reset, then req0 load addr 0x10, memory word 4 = 0xDEADBEEF → mem_read pulse at T+1, address 0x10; resp0_valid at T+3, rdata 0xDEADBEEF, err 0.
- req1 store addr 0x23, wdata 0x11223344, be 1111 → mem_write at T+1, address 0x20, data 0x11223344; resp1_valid at T+2.
- Word 8 = 0xAABBCCDD; req0 store addr 0x20, wdata 0x00001122, be 0011 → read at T+1, write 0xAABB1122 at T+3; resp0 rdata 0xAABB1122 at T+4.
- Both valid, loads, held for 4 transactions → grants alternate 0,1,0,1. Repeat with FIXED_PRIO=1 → all four grants go to 0.
- req1 load addr 0x1000, MEM_WORDS=1024 → no strobe; resp1_valid at T+1, err 1, rdata 0.
- Assert reset in the RD_CAP cycle of an RMW → no mem_write, no resp; all outputs 0 next cycle; the next simultaneous request grants requester 0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the requesters, the data-memory arbiter and the memory.
// slave: arbiter view; master: requester/memory (testbench) view.
interface dmem_arbiter_if;
    logic        req0_valid;
    logic        req0_write;
    logic [31:0] req0_address;
    logic [31:0] req0_wdata;
    logic [3:0]  req0_byte_en;
    logic        req0_ready;
    logic        resp0_valid;
    logic [31:0] resp0_rdata;
    logic        resp0_err;

    logic        req1_valid;
    logic        req1_write;
    logic [31:0] req1_address;
    logic [31:0] req1_wdata;
    logic [3:0]  req1_byte_en;
    logic        req1_ready;
    logic        resp1_valid;
    logic [31:0] resp1_rdata;
    logic        resp1_err;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  req0_valid, req0_write, req0_address, req0_wdata, req0_byte_en,
        output req0_ready, resp0_valid, resp0_rdata, resp0_err,
        input  req1_valid, req1_write, req1_address, req1_wdata, req1_byte_en,
        output req1_ready, resp1_valid, resp1_rdata, resp1_err,
        output mem_read, mem_write, mem_address, mem_write_data,
        input  mem_read_data
    );

    modport master (
        output req0_valid, req0_write, req0_address, req0_wdata, req0_byte_en,
        input  req0_ready, resp0_valid, resp0_rdata, resp0_err,
        output req1_valid, req1_write, req1_address, req1_wdata, req1_byte_en,
        input  req1_ready, resp1_valid, resp1_rdata, resp1_err,
        input  mem_read, mem_write, mem_address, mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for a single-port
// word memory: loads, full stores, read-modify-write sub-word stores and
// out-of-range rejection.
// Ports: clk, reset (sync, active-high), bus (dmem_arbiter_if.slave):
//   req0/req1 valid/ready request channels, resp0/resp1 completion pulses,
//   mem_* strobes toward the memory (read data valid one cycle after read).
module dmem_arbiter #(
    parameter int MEM_WORDS  = 1024,
    parameter bit FIXED_PRIO = 1'b0
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [2:0] {IDLE, RD, RD_CAP, WR, RESP} state_t;

    localparam logic [31:0] LP_WORDS = 32'(MEM_WORDS);

    state_t      r_state;
    logic        r_prio;
    logic        r_id;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_rv0;
    logic        r_rv1;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_idle;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_write;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic        w_oob;
    logic [31:0] w_mask;
    logic [31:0] w_merge;

    // r_prio = 1 favours requester 1 on a tie.
    assign w_idle = (r_state == IDLE) && !reset;
    assign w_gnt0 = w_idle && bus.req0_valid &&
                    (!bus.req1_valid || FIXED_PRIO || !r_prio);
    assign w_gnt1 = w_idle && bus.req1_valid && !w_gnt0;

    assign w_write = w_gnt1 ? bus.req1_write   : bus.req0_write;
    assign w_addr  = w_gnt1 ? bus.req1_address : bus.req0_address;
    assign w_wdata = w_gnt1 ? bus.req1_wdata   : bus.req0_wdata;
    assign w_be    = w_gnt1 ? bus.req1_byte_en : bus.req0_byte_en;
    assign w_oob   = (w_addr >> 2) >= LP_WORDS;

    // Store lanes from the request, remaining lanes from the read word.
    assign w_mask  = {{8{r_be[3]}}, {8{r_be[2]}},
                      {8{r_be[1]}}, {8{r_be[0]}}};
    assign w_merge = (r_wdata & w_mask) | (bus.mem_read_data & ~w_mask);

    assign bus.req0_ready     = w_gnt0;
    assign bus.req1_ready     = w_gnt1;
    assign bus.resp0_valid    = r_rv0;
    assign bus.resp1_valid    = r_rv1;
    assign bus.resp0_rdata    = r_rv0 ? r_rdata : 32'h0;
    assign bus.resp1_rdata    = r_rv1 ? r_rdata : 32'h0;
    assign bus.resp0_err      = r_rv0 & r_err;
    assign bus.resp1_err      = r_rv1 & r_err;
    assign bus.mem_read       = r_mem_read;
    assign bus.mem_write      = r_mem_write;
    assign bus.mem_address    = r_mem_addr;
    assign bus.mem_write_data = r_mem_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_prio      <= 1'b0;
            r_id        <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_be        <= 4'h0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_rv0       <= 1'b0;
            r_rv1       <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= 32'h0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_prio  <= w_gnt0;
                        r_id    <= w_gnt1;
                        r_write <= w_write;
                        r_addr  <= w_addr & 32'hFFFF_FFFC;
                        r_wdata <= w_wdata;
                        r_be    <= w_be;
                        if (w_oob) begin
                            r_state <= RESP;
                            r_err   <= 1'b1;
                            r_rdata <= 32'h0;
                            r_rv0   <= w_gnt0;
                            r_rv1   <= w_gnt1;
                        end else if (!w_write || (w_be != 4'hF && w_be != 4'h0)) begin
                            // Loads and partial stores both start with a read.
                            r_state    <= RD;
                            r_mem_read <= 1'b1;
                            r_mem_addr <= w_addr & 32'hFFFF_FFFC;
                        end else if (w_be == 4'hF) begin
                            r_state     <= WR;
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= w_addr & 32'hFFFF_FFFC;
                            r_mem_wdata <= w_wdata;
                        end else begin
                            r_state <= RESP;
                            r_err   <= 1'b0;
                            r_rdata <= 32'h0;
                            r_rv0   <= w_gnt0;
                            r_rv1   <= w_gnt1;
                        end
                    end
                end
                RD: begin
                    r_state    <= RD_CAP;
                    r_mem_read <= 1'b0;
                    r_mem_addr <= 32'h0;
                end
                RD_CAP: begin
                    if (r_write) begin
                        r_state     <= WR;
                        r_mem_write <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= w_merge;
                    end else begin
                        r_state <= RESP;
                        r_err   <= 1'b0;
                        r_rdata <= bus.mem_read_data;
                        r_rv0   <= !r_id;
                        r_rv1   <= r_id;
                    end
                end
                WR: begin
                    r_state     <= RESP;
                    r_mem_write <= 1'b0;
                    r_mem_addr  <= 32'h0;
                    r_mem_wdata <= 32'h0;
                    r_err       <= 1'b0;
                    r_rdata     <= r_mem_wdata;
                    r_rv0       <= !r_id;
                    r_rv1       <= r_id;
                end
                RESP: begin
                    r_state <= IDLE;
                    r_rv0   <= 1'b0;
                    r_rv1   <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdata <= 32'h0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
